fifo_rd_adapter: RTL and testbench

Read-side adapter for the team's 8-entry synchronous FIFO (`syn_fifo`). It drains the FIFO through its `read_e` / `data_out` / `empty` port and absorbs the FIFO's one-cycle registered read latency in a 2-entry buffer. Data leaves on a valid/ready stream with a frame marker every `FRAME_LEN` words. It sits between the FIFO and any downstream consumer that applies backpressure.

---
 rtl/fifo_rd_pkg.sv | 21 ++
 rtl/rd_skid_buf.sv | 64 ++++++
 rtl/fifo_rd_adapter.sv | 90 +++++++++
 tb/tb_fifo_rd_adapter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_pkg
//  Description : Shared constants for the syn_fifo read-side adapter.
//                DATA_W_DEF / FRAME_LEN_DEF are the default word width and
//                frame length; CNT_W is the width of the frame word counter;
//                RD_BUF_DEPTH is the depth of the read-latency buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_rd_pkg;

   localparam int DATA_W_DEF    = 8;
   localparam int FRAME_LEN_DEF = 4;
   localparam int CNT_W         = 8;
   localparam int RD_BUF_DEPTH  = 2;

   // Occupancy must represent 0..RD_BUF_DEPTH inclusive.
   localparam int OCC_W         = $clog2(RD_BUF_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rd_skid_buf
//  Description : 2-entry circular buffer that absorbs the FIFO read latency.
//                Push writes at the tail, pop advances the head; a push and
//                a pop in the same cycle leave the occupancy unchanged.
//  Ports       : clk          - rising-edge clock
//                reset        - asynchronous active-low reset
//                i_push       - write i_push_data at the tail
//                i_push_data  - word to store
//                i_pop        - discard the head entry
//                o_occ        - number of stored words, 0..2
//                o_head_data  - oldest stored word
//  Revision    : 1.0  initial release
// ============================================================================
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [OCC_W-1:0]  o_occ,
   output logic [DATA_W-1:0] o_head_data
);

   // Depth is two, so head and tail are single-bit pointers that toggle.
   logic [DATA_W-1:0] r_mem [RD_BUF_DEPTH];
   logic              r_head;
   logic              r_tail;
   logic [OCC_W-1:0]  r_occ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RD_BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_head <= 1'b0;
         r_tail <= 1'b0;
         r_occ  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_tail] <= i_push_data;
            r_tail        <= ~r_tail;
         end
         if (i_pop) begin
            r_head <= ~r_head;
         end
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_occ       = r_occ;
   assign o_head_data = r_mem[r_head];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_adapter
//  Description : Drains syn_fifo through read_e/data_out/empty, hides its
//                one-cycle read latency in a 2-entry buffer and presents the
//                words on a valid/ready stream with a frame marker every
//                FRAME_LEN words.
//  Ports       : clk, reset (async, active-low)
//                enable       - permits new FIFO reads
//                fifo_empty   - FIFO empty flag
//                fifo_data    - FIFO read data, valid the cycle after a read
//                fifo_read_e  - FIFO read strobe
//                m_valid / m_ready / m_data - output stream handshake + data
//                m_last       - last word of the current frame
//                word_cnt     - index of the current word within its frame
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rd_adapter
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_read_e,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(FRAME_LEN - 1);

   logic               r_inflight;
   logic [CNT_W-1:0]   r_word_cnt;

   logic [OCC_W-1:0]   w_occ;
   logic [DATA_W-1:0]  w_head;
   logic [OCC_W:0]     w_held;
   logic               w_room;
   logic               w_pop;
   logic               w_rd;

   // Words already committed: buffered plus the one arriving this cycle.
   assign w_held = {1'b0, w_occ} + (OCC_W + 1)'(r_inflight);
   assign w_room = (w_held < (OCC_W + 1)'(RD_BUF_DEPTH));
   assign w_pop  = m_valid && m_ready;

   // A pop this cycle frees a slot in time for the word this read returns,
   // which is what keeps the stream at one word per cycle; hence the
   // combinational path from m_ready.
   assign w_rd   = enable && !fifo_empty && (w_room || w_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_inflight <= 1'b0;
         r_word_cnt <= '0;
      end else begin
         r_inflight <= w_rd;
         if (w_pop) begin
            r_word_cnt <= (r_word_cnt == c_LAST_IDX) ? '0 : r_word_cnt + CNT_W'(1);
         end
      end
   end

   rd_skid_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk         (clk),
      .reset       (reset),
      .i_push      (r_inflight),
      .i_push_data (fifo_data),
      .i_pop       (w_pop),
      .o_occ       (w_occ),
      .o_head_data (w_head)
   );

   assign fifo_read_e = w_rd;
   assign m_valid     = (w_occ != '0);
   assign m_data      = w_head;
   assign m_last      = (r_word_cnt == c_LAST_IDX);
   assign word_cnt    = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_adapter
//  Description : Self-checking bench for fifo_rd_adapter. A queue stands in
//                for syn_fifo (registered read data, empty flag), and a
//                queue-based reference model predicts the stream outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_rd_adapter;

   localparam int DATA_W    = 8;
   localparam int FRAME_LEN = 4;

   logic              clk        = 1'b0;
   logic              reset      = 1'b1;
   logic              enable     = 1'b0;
   logic              fifo_empty = 1'b1;
   logic [DATA_W-1:0] fifo_data  = '0;
   logic              m_ready    = 1'b0;
   logic              fifo_read_e;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic [7:0]        word_cnt;

   always #5 clk = ~clk;

   fifo_rd_adapter #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_read_e (fifo_read_e),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .word_cnt    (word_cnt)
   );

   logic [7:0] fifo_q[$];      // FIFO contents
   logic [7:0] buf_q[$];       // words the adapter should be holding
   logic [7:0] obs_q[$];       // words the DUT handed over
   bit         obs_last_q[$];
   int         obs_cyc_q[$];
   bit         vhist[$];
   bit         infl;
   logic [7:0] infl_w;
   int         pops, rd_count, cyc;
   int         checks, errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: check at the falling edge, advance FIFO and model at
   // the rising edge, return 1ns after it so the caller can drive inputs.
   task automatic step();
      bit exp_valid, pop, rd;
      int held;
      @(negedge clk);
      exp_valid = (buf_q.size() != 0);
      pop       = exp_valid && m_ready;
      held      = buf_q.size() + (infl ? 1 : 0);
      chk("read_e", fifo_read_e, enable && !fifo_empty && (held < 2 || pop));
      chk("m_valid", m_valid, exp_valid);
      if (exp_valid) chk("m_data", m_data, buf_q[0]);
      chk("word_cnt", word_cnt, pops % FRAME_LEN);
      chk("m_last", m_last, (pops % FRAME_LEN) == FRAME_LEN - 1);
      vhist.push_back(m_valid);
      if (m_valid && m_ready) begin
         obs_q.push_back(m_data);
         obs_last_q.push_back(m_last);
         obs_cyc_q.push_back(cyc);
      end
      rd = fifo_read_e;
      if (rd) rd_count++;
      @(posedge clk);
      if (pop) begin
         void'(buf_q.pop_front());
         pops++;
      end
      if (infl) buf_q.push_back(infl_w);
      infl = rd && (fifo_q.size() != 0);
      if (infl) infl_w = fifo_q.pop_front();
      chk("no_overflow", (buf_q.size() + (infl ? 1 : 0)) <= 2, 1);
      #1;
      if (infl) fifo_data = infl_w;
      fifo_empty = (fifo_q.size() == 0);
      cyc++;
   endtask

   // Asserts reset (with the FIFO reset alongside) and checks the outputs
   // settle asynchronously, before any clock edge.
   task automatic do_reset();
      reset   = 1'b0;
      enable  = 1'b0;
      m_ready = 1'b0;
      fifo_q.delete();
      fifo_empty = 1'b1;
      fifo_data  = '0;
      buf_q.delete();
      infl = 1'b0;
      pops = 0;
      #1;
      chk("rst_read_e", fifo_read_e, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, FRAME_LEN == 1);
      chk("rst_word_cnt", word_cnt, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      fifo_q.push_back(v);
      fifo_empty = 1'b0;
   endtask

   task automatic clear_logs();
      obs_q.delete();
      obs_last_q.delete();
      obs_cyc_q.delete();
      vhist.delete();
      rd_count = 0;
   endtask

   task automatic check_seq(input string tag, input logic [7:0] first,
                            input logic [7:0] incr, input int n);
      chk({tag, "_count"}, obs_q.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < obs_q.size()) chk({tag, "_word"}, obs_q[i], 8'(first + i * incr));
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; pops = 0; rd_count = 0; infl = 1'b0;
      #2;
      do_reset();

      // T1: three preloaded words, first-word latency
      load(8'h11); load(8'h22); load(8'h33);
      reset = 1'b1; enable = 1'b1; m_ready = 1'b1;
      clear_logs();
      repeat (7) step();
      chk("t1_reads", rd_count, 3);
      check_seq("t1", 8'h11, 8'h11, 3);
      chk("t1_word_cnt", word_cnt, 3);

      // T2: eight-word stream, frame markers
      do_reset();
      for (int i = 0; i < 8; i++) load(8'(i));
      reset = 1'b1; enable = 1'b1; m_ready = 1'b1;
      clear_logs();
      repeat (12) step();
      check_seq("t2", 8'h00, 8'h01, 8);
      for (int i = 0; i < 8; i++) begin
         if (i < obs_last_q.size()) chk("t2_last", obs_last_q[i], (i % 4) == 3);
      end
      chk("t2_word_cnt", word_cnt, 0);

      // T3: backpressure with five words available
      do_reset();
      for (int i = 0; i < 5; i++) load(8'(8'h40 + i));
      reset = 1'b1; enable = 1'b1; m_ready = 1'b0;
      clear_logs();
      repeat (6) step();
      chk("t3_reads", rd_count, 2);
      chk("t3_hold_valid", m_valid, 1);
      chk("t3_hold_data", m_data, 8'h40);
      m_ready = 1'b1;
      repeat (8) step();
      check_seq("t3", 8'h40, 8'h01, 5);
      for (int i = 1; i < 5; i++) begin
         if (i < obs_cyc_q.size()) chk("t3_gap", obs_cyc_q[i] - obs_cyc_q[i-1], 1);
      end

      // T4: enable dropped the cycle after the first read
      do_reset();
      load(8'hA0); load(8'hA1); load(8'hA2);
      reset = 1'b1; enable = 1'b1; m_ready = 1'b1;
      clear_logs();
      step();
      enable = 1'b0;
      repeat (5) step();
      chk("t4_reads", rd_count, 1);
      check_seq("t4a", 8'hA0, 8'h01, 1);
      enable = 1'b1;
      repeat (6) step();
      check_seq("t4b", 8'hA0, 8'h01, 3);
      chk("t4_word_cnt", word_cnt, 3);

      // T5: empty FIFO, then a single write
      do_reset();
      reset = 1'b1; enable = 1'b1; m_ready = 1'b1;
      clear_logs();
      repeat (4) step();
      chk("t5_reads", rd_count, 0);
      chk("t5_idle_words", obs_q.size(), 0);
      load(8'h5C);
      vhist.delete();
      repeat (3) step();
      chk("t5_valid_c0", vhist[0], 0);
      chk("t5_valid_c1", vhist[1], 0);
      chk("t5_valid_c2", vhist[2], 1);
      check_seq("t5", 8'h5C, 8'h00, 1);

      // T6: reset while the buffer is full
      do_reset();
      for (int i = 0; i < 5; i++) load(8'(8'h60 + i));
      reset = 1'b1; enable = 1'b1; m_ready = 1'b0;
      repeat (4) step();
      chk("t6_pre_valid", m_valid, 1);
      do_reset();
      reset = 1'b1; enable = 1'b1; m_ready = 1'b1;
      clear_logs();
      repeat (4) step();
      chk("t6_no_stale", obs_q.size(), 0);
      load(8'h77);
      repeat (4) step();
      check_seq("t6", 8'h77, 8'h00, 1);

      // Randomized traffic against the reference model
      do_reset();
      reset = 1'b1;
      clear_logs();
      for (int i = 0; i < 600; i++) begin
         enable  = ($urandom_range(0, 7) != 0);
         m_ready = ($urandom_range(0, 3) != 0);
         if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) load(8'($urandom_range(0, 255)));
         step();
      end
      enable  = 1'b0;
      m_ready = 1'b1;
      repeat (6) step();
      chk("rand_total", obs_q.size(), pops);
      chk("rand_drained", m_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
